lsu_mc: RTL and testbench
=========================

LSU_MC -- requirements
Module: lsu_mc

Interface
REQ-001 Parameter XLEN, default 32, SHALL be the data path width; legal values are 32 and 64.
REQ-002 Parameter ADDR_W, default 32, SHALL be the address width.
REQ-003 clk  in  1  SHALL be the single clock; all state updates on rising edge.
REQ-004 rst_n  in  1  SHALL be the reset: asynchronous, active-low.
REQ-005 req_valid_i  in  1 / req_ready_o  out  1  SHALL be the request handshake; a transfer occurs when both are high.
REQ-006 ls_type_i  in  LS_TYPE_W  SHALL be the access type; MSB=1 means store.
REQ-007 addr_i  in  ADDR_W / store_data_i  in  XLEN / rd_i  in  5  SHALL be the address, the store data and the destination register.
REQ-008 dbus_req_o  out  1 / dbus_gnt_i  in  1  SHALL be the bus command handshake.
REQ-009 dbus_we_o  out  1 / dbus_addr_o  out  ADDR_W / dbus_wdata_o  out  XLEN / dbus_sel_o  out  XLEN/8  SHALL be the command payload; dbus_addr_o is aligned down to XLEN/8 bytes.
REQ-010 dbus_rvalid_i  in  1 / dbus_rdata_i  in  XLEN / dbus_err_i  in  1  SHALL be the response; stores are also acked via rvalid.
REQ-011 resp_valid_o  out  1 / resp_we_o  out  1 / resp_rd_o  out  5 / resp_data_o  out  XLEN  SHALL be the writeback result.
REQ-012 misalign_o  out  1 / bus_err_o  out  1  SHALL be exception flags, qualified by resp_valid_o; busy_o  out  1  SHALL be high whenever state != IDLE.

Function
REQ-013 FSM states SHALL be IDLE, REQ, WAIT, RESP; req_ready_o=1 only in IDLE.
REQ-014 On an accepted request the type, rd, aligned address, byte-lane sel and lane-shifted store data SHALL be registered, and the FSM SHALL go to REQ (or to RESP if misaligned).
REQ-015 Misaligned: half addr[0]!=0; word addr[1:0]!=0; double (XLEN=64 only) addr[2:0]!=0. Misaligned requests SHALL issue no bus command and SHALL respond next cycle with misalign_o=1, resp_we_o=0.
REQ-016 In REQ, dbus_req_o=1 and the payload SHALL be held stable until dbus_gnt_i=1; then go to WAIT, or to RESP directly if dbus_rvalid_i=1 in the same cycle.
REQ-017 In WAIT, on dbus_rvalid_i=1 the lane-extracted, sign/zero-extended load result SHALL be registered, and the FSM SHALL go to RESP.
REQ-018 In RESP, resp_valid_o=1 for exactly one cycle, then IDLE; there is no back-pressure on the response.
REQ-019 resp_we_o SHALL be 1 only for a load with rd!=0, no misalignment and no bus error; for stores resp_data_o=0.
REQ-020 dbus_err_i with rvalid SHALL set bus_err_o=1 and force resp_we_o=0.
REQ-021 sel: byte = one lane at addr offset; half = two lanes; word = four lanes; double = all eight lanes.
REQ-022 Minimum aligned latency SHALL be: accept T, dbus_req_o T+1, resp_valid_o T+3 (gnt at T+1, rvalid at T+2).
REQ-023 LD/LWU/SD on XLEN=32 SHALL be treated as illegal: respond like a misaligned access.

Reset
REQ-024 Asynchronous reset SHALL force IDLE immediately and zero all outputs except req_ready_o=1; an outstanding bus transaction is abandoned, and a late rvalid after reset is ignored in IDLE.

Structure
REQ-025 Package lsu_pkg SHALL hold LS_TYPE_W, the encodings LB, LH, LW, LD, LBU, LHU, LWU, SB, SH, SW, SD, NONE, and the FSM state enum.
REQ-026 One sub-module, lsu_align, SHALL be purely combinational and compute sel, store-lane shift, load extraction/extension and the misalign flag; the FSM and registers stay in lsu_mc.

Verification
REQ-027 XLEN=32, LB addr 0x1003, rdata 0x80FF_0000, gnt immediate, rvalid next -> resp_data 0xFFFF_FF80, sel 0b1000, resp_valid at T+3.
REQ-028 LHU addr 0x2002, rdata 0xBEEF_1234 -> resp_data 0x0000_BEEF; SH addr 0x2002, data 0x5678 -> wdata 0x5678_0000, sel 0b1100, we=1, resp_we=0.
REQ-029 LW addr 0x3001 -> no dbus_req_o, resp_valid at T+1, misalign_o=1, resp_we=0.
REQ-030 gnt delayed 3 cycles -> dbus_addr/wdata/sel stable during all REQ cycles; req_ready_o=0 throughout.
REQ-031 LW rd=5, rvalid with dbus_err_i=1 -> bus_err_o=1, resp_we=0; LW rd=0 -> resp_we=0.
REQ-032 rst_n low while in WAIT -> immediate IDLE, outputs zero, req_ready_o=1; a subsequent stray rvalid produces no resp_valid.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types for the multi-cycle load/store unit.
// Access-type encodings, size classes and FSM states.
package lsu_pkg;

    localparam int LS_TYPE_W = 4;

    // bit3 = store, bit2 = unsigned load, bits[1:0] = log2(size)
    localparam logic [LS_TYPE_W-1:0] LB   = 4'b0000;
    localparam logic [LS_TYPE_W-1:0] LH   = 4'b0001;
    localparam logic [LS_TYPE_W-1:0] LW   = 4'b0010;
    localparam logic [LS_TYPE_W-1:0] LD   = 4'b0011;
    localparam logic [LS_TYPE_W-1:0] LBU  = 4'b0100;
    localparam logic [LS_TYPE_W-1:0] LHU  = 4'b0101;
    localparam logic [LS_TYPE_W-1:0] LWU  = 4'b0110;
    localparam logic [LS_TYPE_W-1:0] NONE = 4'b0111;
    localparam logic [LS_TYPE_W-1:0] SB   = 4'b1000;
    localparam logic [LS_TYPE_W-1:0] SH   = 4'b1001;
    localparam logic [LS_TYPE_W-1:0] SW   = 4'b1010;
    localparam logic [LS_TYPE_W-1:0] SD   = 4'b1011;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        RESP
    } lsu_state_e;

    typedef enum logic [1:0] {
        SZ_B,
        SZ_H,
        SZ_W,
        SZ_D
    } ls_size_e;

    function automatic logic ls_is_store(input logic [LS_TYPE_W-1:0] t);
        return t[LS_TYPE_W-1];
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: byte enables, store shift,
// load extraction/extension and misalign/illegal detection.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [LS_TYPE_W-1:0]      req_type,
    input  logic [$clog2(XLEN/8)-1:0] req_off,
    input  logic [XLEN-1:0]           store_data,
    output logic [XLEN/8-1:0]         sel,
    output logic [XLEN-1:0]           wdata,
    output logic                      misalign,
    input  logic [LS_TYPE_W-1:0]      ld_type,
    input  logic [$clog2(XLEN/8)-1:0] ld_off,
    input  logic [XLEN-1:0]           rdata,
    output logic [XLEN-1:0]           load_data
);

    localparam int NB = XLEN / 8;

    ls_size_e        req_size;
    ls_size_e        ld_size;
    logic            illegal;
    logic            unal;
    logic [2:0]      off3;
    logic [7:0]      base;
    logic [XLEN-1:0] lane_mask;
    logic [XLEN-1:0] shifted;
    logic            sx;
    int              bits;

    always_comb begin
        req_size = ls_size_e'(req_type[1:0]);
        off3     = 3'(req_off);
        illegal  = (req_type == NONE) ||
                   (req_type[LS_TYPE_W-1 -: 2] == 2'b11);
        // 64-bit accesses and LWU have no meaning on a 32-bit datapath
        if (XLEN == 32 && (req_size == SZ_D || req_type == LWU))
            illegal = 1'b1;
        unique case (req_size)
            SZ_B: begin unal = 1'b0;      base = 8'h01; end
            SZ_H: begin unal = off3[0];   base = 8'h03; end
            SZ_W: begin unal = |off3[1:0]; base = 8'h0F; end
            SZ_D: begin unal = |off3;     base = 8'hFF; end
            default: begin unal = 1'b1;   base = 8'h00; end
        endcase
        misalign = illegal | unal;
        sel = base[NB-1:0] << req_off;
        for (int i = 0; i < NB; i++)
            lane_mask[8*i +: 8] = {8{sel[i]}};
        wdata = (store_data << {req_off, 3'b000}) & lane_mask;
    end

    always_comb begin
        ld_size = ls_size_e'(ld_type[1:0]);
        shifted = rdata >> {ld_off, 3'b000};
        unique case (ld_size)
            SZ_B:    bits = 8;
            SZ_H:    bits = 16;
            SZ_W:    bits = 32;
            SZ_D:    bits = 64;
            default: bits = 8;
        endcase
        if (bits > XLEN)
            bits = XLEN;
        sx = ~ld_type[2] & shifted[bits-1];
        for (int i = 0; i < XLEN; i++)
            load_data[i] = (i < bits) ? shifted[i] : sx;
    end

endmodule

// File: rtl/lsu_mc.sv
// Multi-cycle load/store unit: one outstanding access,
// IDLE -> REQ -> WAIT -> RESP with a one-cycle writeback pulse.
module lsu_mc
    import lsu_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic [LS_TYPE_W-1:0] ls_type_i,
    input  logic [ADDR_W-1:0]    addr_i,
    input  logic [XLEN-1:0]      store_data_i,
    input  logic [4:0]           rd_i,
    output logic                 dbus_req_o,
    input  logic                 dbus_gnt_i,
    output logic                 dbus_we_o,
    output logic [ADDR_W-1:0]    dbus_addr_o,
    output logic [XLEN-1:0]      dbus_wdata_o,
    output logic [XLEN/8-1:0]    dbus_sel_o,
    input  logic                 dbus_rvalid_i,
    input  logic [XLEN-1:0]      dbus_rdata_i,
    input  logic                 dbus_err_i,
    output logic                 resp_valid_o,
    output logic                 resp_we_o,
    output logic [4:0]           resp_rd_o,
    output logic [XLEN-1:0]      resp_data_o,
    output logic                 misalign_o,
    output logic                 bus_err_o,
    output logic                 busy_o
);

    localparam int NB    = XLEN / 8;
    localparam int OFF_W = $clog2(NB);

    lsu_state_e           state;
    logic [LS_TYPE_W-1:0] type_q;
    logic [4:0]           rd_q;
    logic [ADDR_W-1:0]    addr_q;
    logic [OFF_W-1:0]     off_q;
    logic [NB-1:0]        sel_q;
    logic [XLEN-1:0]      wdata_q;
    logic [XLEN-1:0]      data_q;
    logic                 mis_q;
    logic                 err_q;

    logic [NB-1:0]        sel_c;
    logic [XLEN-1:0]      wdata_c;
    logic [XLEN-1:0]      load_c;
    logic [XLEN-1:0]      rsp_c;
    logic                 mis_c;
    logic                 in_req;
    logic                 in_resp;
    logic                 store_q;

    lsu_align #(
        .XLEN(XLEN)
    ) u_align (
        .req_type  (ls_type_i),
        .req_off   (addr_i[OFF_W-1:0]),
        .store_data(store_data_i),
        .sel       (sel_c),
        .wdata     (wdata_c),
        .misalign  (mis_c),
        .ld_type   (type_q),
        .ld_off    (off_q),
        .rdata     (dbus_rdata_i),
        .load_data (load_c)
    );

    assign store_q = ls_is_store(type_q);
    assign in_req  = (state == REQ);
    assign in_resp = (state == RESP);
    assign rsp_c   = (store_q | dbus_err_i) ? '0 : load_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            type_q  <= '0;
            rd_q    <= '0;
            addr_q  <= '0;
            off_q   <= '0;
            sel_q   <= '0;
            wdata_q <= '0;
            data_q  <= '0;
            mis_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: if (req_valid_i) begin
                    type_q  <= ls_type_i;
                    rd_q    <= rd_i;
                    addr_q  <= {addr_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                    off_q   <= addr_i[OFF_W-1:0];
                    sel_q   <= sel_c;
                    wdata_q <= wdata_c;
                    mis_q   <= mis_c;
                    err_q   <= 1'b0;
                    data_q  <= '0;
                    state   <= mis_c ? RESP : REQ;
                end
                REQ: if (dbus_gnt_i) begin
                    // a zero-wait slave may answer in the grant cycle
                    if (dbus_rvalid_i) begin
                        err_q  <= dbus_err_i;
                        data_q <= rsp_c;
                        state  <= RESP;
                    end else begin
                        state <= WAIT;
                    end
                end
                WAIT: if (dbus_rvalid_i) begin
                    err_q  <= dbus_err_i;
                    data_q <= rsp_c;
                    state  <= RESP;
                end
                RESP: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign req_ready_o  = (state == IDLE);
    assign busy_o       = (state != IDLE);

    assign dbus_req_o   = in_req;
    assign dbus_we_o    = in_req & store_q;
    assign dbus_addr_o  = in_req ? addr_q : '0;
    assign dbus_wdata_o = in_req ? wdata_q : '0;
    assign dbus_sel_o   = in_req ? sel_q : '0;

    assign resp_valid_o = in_resp;
    assign resp_we_o    = in_resp & ~store_q & (rd_q != 5'd0) & ~mis_q & ~err_q;
    assign resp_rd_o    = in_resp ? rd_q : 5'd0;
    assign resp_data_o  = in_resp ? data_q : '0;
    assign misalign_o   = in_resp & mis_q;
    assign bus_err_o    = in_resp & err_q;

endmodule

// File: tb/tb_lsu_mc.sv
// Self-checking bench for lsu_mc (XLEN=32): directed cases
// plus randomized accesses against a byte-level reference model.
module tb_lsu_mc;
    import lsu_pkg::*;

    localparam int XLEN   = 32;
    localparam int ADDR_W = 32;

    logic        clk;
    logic        rst_n;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [3:0]  ls_type_i;
    logic [31:0] addr_i;
    logic [31:0] store_data_i;
    logic [4:0]  rd_i;
    logic        dbus_req_o;
    logic        dbus_gnt_i;
    logic        dbus_we_o;
    logic [31:0] dbus_addr_o;
    logic [31:0] dbus_wdata_o;
    logic [3:0]  dbus_sel_o;
    logic        dbus_rvalid_i;
    logic [31:0] dbus_rdata_i;
    logic        dbus_err_i;
    logic        resp_valid_o;
    logic        resp_we_o;
    logic [4:0]  resp_rd_o;
    logic [31:0] resp_data_o;
    logic        misalign_o;
    logic        bus_err_o;
    logic        busy_o;

    int n_chk;
    int n_pass;

    lsu_mc #(.XLEN(XLEN), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .ls_type_i(ls_type_i), .addr_i(addr_i),
        .store_data_i(store_data_i), .rd_i(rd_i),
        .dbus_req_o(dbus_req_o), .dbus_gnt_i(dbus_gnt_i),
        .dbus_we_o(dbus_we_o), .dbus_addr_o(dbus_addr_o),
        .dbus_wdata_o(dbus_wdata_o), .dbus_sel_o(dbus_sel_o),
        .dbus_rvalid_i(dbus_rvalid_i), .dbus_rdata_i(dbus_rdata_i),
        .dbus_err_i(dbus_err_i),
        .resp_valid_o(resp_valid_o), .resp_we_o(resp_we_o),
        .resp_rd_o(resp_rd_o), .resp_data_o(resp_data_o),
        .misalign_o(misalign_o), .bus_err_o(bus_err_o),
        .busy_o(busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // observations from one transaction
    logic        o_timeout, o_unstable, o_ready_busy, o_one_cycle;
    int          o_req_cycles, o_first_req, o_resp_cyc;
    logic        o_dwe, o_rwe, o_mis, o_berr;
    logic [31:0] o_daddr, o_dwdata, o_rdata;
    logic [3:0]  o_dsel;
    logic [4:0]  o_rd;

    // reference expectations
    logic        e_mis, e_dwe, e_rwe, e_berr;
    logic [3:0]  e_sel;
    logic [31:0] e_wdata, e_daddr, e_data;
    int          e_lat;

    function automatic void model(input logic [3:0] ty, input logic [31:0] addr,
                                  input logic [31:0] sd, input logic [4:0] rd,
                                  input int gd, input int rvd,
                                  input logic [31:0] rdat, input logic err);
        int size;
        int off;
        bit legal, uns, st;
        logic [31:0] v;
        size = 1; legal = 1; uns = 0;
        st = ty[3];
        case (ty)
            LB, SB:  size = 1;
            LH, SH:  size = 2;
            LW, SW:  size = 4;
            LBU: begin size = 1; uns = 1; end
            LHU: begin size = 2; uns = 1; end
            default: legal = 0;
        endcase
        off = int'(addr % 4);
        e_mis = !legal || (addr % size != 0);
        e_sel = 4'(((1 << size) - 1) << off);
        e_wdata = '0;
        for (int i = 0; i < 4; i++)
            if (e_sel[i]) e_wdata[8*i +: 8] = sd[8*(i-off) +: 8];
        v = '0;
        for (int j = 0; j < size && off + j < 4; j++)
            v[8*j +: 8] = rdat[8*(off+j) +: 8];
        if (!uns && v[8*size-1])
            for (int j = 8*size; j < 32; j++) v[j] = 1'b1;
        e_daddr = addr & 32'hFFFF_FFFC;
        e_dwe   = st;
        e_berr  = !e_mis && err;
        e_rwe   = !st && !e_mis && !err && (rd != 0);
        e_data  = (st || e_mis || err) ? 32'h0 : v;
        e_lat   = e_mis ? 1 : 2 + gd + rvd;
    endfunction

    task automatic run_txn(input logic [3:0] ty, input logic [31:0] addr,
                           input logic [31:0] sd, input logic [4:0] rd,
                           input int gd, input int rvd,
                           input logic [31:0] rdat, input logic err);
        int c, gat;
        logic granted;
        o_timeout = 1; o_unstable = 0; o_ready_busy = 0; o_one_cycle = 0;
        o_req_cycles = 0; o_first_req = -1; o_resp_cyc = -1;
        @(negedge clk);
        req_valid_i = 1; ls_type_i = ty; addr_i = addr;
        store_data_i = sd; rd_i = rd;
        @(negedge clk);
        req_valid_i = 0;
        c = 1; granted = 0; gat = 0;
        for (int k = 0; k < 40; k++) begin
            dbus_gnt_i = 0; dbus_rvalid_i = 0; dbus_err_i = 0; dbus_rdata_i = '0;
            if (req_ready_o) o_ready_busy = 1;
            if (dbus_req_o) begin
                o_req_cycles++;
                if (o_req_cycles == 1) begin
                    o_first_req = c; o_daddr = dbus_addr_o;
                    o_dwdata = dbus_wdata_o; o_dsel = dbus_sel_o; o_dwe = dbus_we_o;
                end else if (o_daddr !== dbus_addr_o || o_dwdata !== dbus_wdata_o ||
                             o_dsel !== dbus_sel_o || o_dwe !== dbus_we_o) begin
                    o_unstable = 1;
                end
            end
            if (resp_valid_o) begin
                o_resp_cyc = c; o_timeout = 0;
                o_rwe = resp_we_o; o_rd = resp_rd_o; o_rdata = resp_data_o;
                o_mis = misalign_o; o_berr = bus_err_o;
                break;
            end
            if (dbus_req_o && o_req_cycles == gd + 1) begin
                dbus_gnt_i = 1; granted = 1; gat = c;
            end
            if (granted && c - gat == rvd) begin
                dbus_rvalid_i = 1; dbus_rdata_i = rdat; dbus_err_i = err;
            end
            @(negedge clk);
            c++;
        end
        @(negedge clk);
        o_one_cycle = !resp_valid_o && !busy_o && req_ready_o;
    endtask

    task automatic test_reset();
        n_chk++; if (req_ready_o !== 1'b1) $display("FAIL reset_ready got %b want 1", req_ready_o); else n_pass++;
        n_chk++; if (busy_o !== 1'b0) $display("FAIL reset_busy got %b want 0", busy_o); else n_pass++;
        n_chk++; if (dbus_req_o !== 1'b0) $display("FAIL reset_dbus_req got %b want 0", dbus_req_o); else n_pass++;
        n_chk++; if (resp_valid_o !== 1'b0) $display("FAIL reset_resp_valid got %b want 0", resp_valid_o); else n_pass++;
        n_chk++; if ({dbus_addr_o, dbus_wdata_o, dbus_sel_o} !== '0)
            $display("FAIL reset_payload got %h/%h/%b want 0", dbus_addr_o, dbus_wdata_o, dbus_sel_o); else n_pass++;
    endtask

    task automatic test_lb_sign();
        run_txn(LB, 32'h1003, 32'h0, 5'd7, 0, 1, 32'h80FF_0000, 1'b0);
        n_chk++; if (o_rdata !== 32'hFFFF_FF80) $display("FAIL lb_data got %h want ffffff80", o_rdata); else n_pass++;
        n_chk++; if (o_dsel !== 4'b1000) $display("FAIL lb_sel got %b want 1000", o_dsel); else n_pass++;
        n_chk++; if (o_first_req !== 1) $display("FAIL lb_req_lat got %0d want 1", o_first_req); else n_pass++;
        n_chk++; if (o_resp_cyc !== 3) $display("FAIL lb_resp_lat got %0d want 3", o_resp_cyc); else n_pass++;
        n_chk++; if (o_rwe !== 1'b1 || o_rd !== 5'd7) $display("FAIL lb_we got %b/%0d want 1/7", o_rwe, o_rd); else n_pass++;
        n_chk++; if (o_daddr !== 32'h1000) $display("FAIL lb_addr got %h want 1000", o_daddr); else n_pass++;
    endtask

    task automatic test_half();
        run_txn(LHU, 32'h2002, 32'h0, 5'd3, 0, 1, 32'hBEEF_1234, 1'b0);
        n_chk++; if (o_rdata !== 32'h0000_BEEF) $display("FAIL lhu_data got %h want 0000beef", o_rdata); else n_pass++;
        run_txn(SH, 32'h2002, 32'h0000_5678, 5'd3, 0, 1, 32'h0, 1'b0);
        n_chk++; if (o_dwdata !== 32'h5678_0000) $display("FAIL sh_wdata got %h want 56780000", o_dwdata); else n_pass++;
        n_chk++; if (o_dsel !== 4'b1100) $display("FAIL sh_sel got %b want 1100", o_dsel); else n_pass++;
        n_chk++; if (o_dwe !== 1'b1) $display("FAIL sh_we got %b want 1", o_dwe); else n_pass++;
        n_chk++; if (o_rwe !== 1'b0 || o_rdata !== 32'h0)
            $display("FAIL sh_resp got we=%b data=%h want 0/0", o_rwe, o_rdata); else n_pass++;
    endtask

    task automatic test_misalign();
        run_txn(LW, 32'h3001, 32'h0, 5'd9, 0, 1, 32'h0, 1'b0);
        n_chk++; if (o_req_cycles !== 0) $display("FAIL mis_no_bus got %0d req cycles want 0", o_req_cycles); else n_pass++;
        n_chk++; if (o_resp_cyc !== 1) $display("FAIL mis_lat got %0d want 1", o_resp_cyc); else n_pass++;
        n_chk++; if (o_mis !== 1'b1 || o_rwe !== 1'b0)
            $display("FAIL mis_flags got mis=%b we=%b want 1/0", o_mis, o_rwe); else n_pass++;
        run_txn(LD, 32'h3000, 32'h0, 5'd9, 0, 1, 32'h0, 1'b0);
        n_chk++; if (o_mis !== 1'b1 || o_req_cycles !== 0)
            $display("FAIL ld_illegal got mis=%b req=%0d want 1/0", o_mis, o_req_cycles); else n_pass++;
    endtask

    task automatic test_gnt_delay();
        run_txn(SW, 32'h4008, 32'hCAFE_F00D, 5'd1, 3, 1, 32'h0, 1'b0);
        n_chk++; if (o_unstable !== 1'b0) $display("FAIL gnt_stable got unstable=%b want 0", o_unstable); else n_pass++;
        n_chk++; if (o_ready_busy !== 1'b0) $display("FAIL gnt_ready got %b want 0", o_ready_busy); else n_pass++;
        n_chk++; if (o_req_cycles !== 4) $display("FAIL gnt_req_cycles got %0d want 4", o_req_cycles); else n_pass++;
        n_chk++; if (o_resp_cyc !== 6) $display("FAIL gnt_lat got %0d want 6", o_resp_cyc); else n_pass++;
        n_chk++; if (o_dwdata !== 32'hCAFE_F00D) $display("FAIL gnt_wdata got %h want cafef00d", o_dwdata); else n_pass++;
    endtask

    task automatic test_bus_err();
        run_txn(LW, 32'h5004, 32'h0, 5'd5, 0, 1, 32'h1234_5678, 1'b1);
        n_chk++; if (o_berr !== 1'b1 || o_rwe !== 1'b0)
            $display("FAIL berr got err=%b we=%b want 1/0", o_berr, o_rwe); else n_pass++;
        run_txn(LW, 32'h5004, 32'h0, 5'd0, 0, 1, 32'h1234_5678, 1'b0);
        n_chk++; if (o_rwe !== 1'b0 || o_rdata !== 32'h1234_5678)
            $display("FAIL rd0 got we=%b data=%h want 0/12345678", o_rwe, o_rdata); else n_pass++;
        run_txn(LW, 32'h5008, 32'h0, 5'd2, 1, 0, 32'hA5A5_0001, 1'b0);
        n_chk++; if (o_resp_cyc !== 3 || o_rdata !== 32'hA5A5_0001)
            $display("FAIL same_cycle got lat=%0d data=%h want 3/a5a50001", o_resp_cyc, o_rdata); else n_pass++;
    endtask

    task automatic test_reset_in_wait();
        logic seen;
        @(negedge clk);
        req_valid_i = 1; ls_type_i = LW; addr_i = 32'h6000; rd_i = 5'd4;
        @(negedge clk);
        req_valid_i = 0; dbus_gnt_i = 1;
        @(negedge clk);
        dbus_gnt_i = 0;
        n_chk++; if (busy_o !== 1'b1 || dbus_req_o !== 1'b0)
            $display("FAIL rst_wait_entry got busy=%b req=%b want 1/0", busy_o, dbus_req_o); else n_pass++;
        #2 rst_n = 0;
        #1;
        n_chk++; if (busy_o !== 1'b0 || req_ready_o !== 1'b1)
            $display("FAIL rst_async got busy=%b ready=%b want 0/1", busy_o, req_ready_o); else n_pass++;
        n_chk++; if ({dbus_req_o, resp_valid_o, resp_we_o, misalign_o, bus_err_o, dbus_addr_o} !== '0)
            $display("FAIL rst_outputs got req=%b rv=%b addr=%h want zeros", dbus_req_o, resp_valid_o, dbus_addr_o); else n_pass++;
        @(negedge clk);
        rst_n = 1;
        dbus_rvalid_i = 1; dbus_rdata_i = 32'hDEAD_BEEF;
        @(negedge clk);
        dbus_rvalid_i = 0; dbus_rdata_i = '0;
        seen = 0;
        for (int k = 0; k < 4; k++) begin
            if (resp_valid_o || busy_o) seen = 1;
            @(negedge clk);
        end
        n_chk++; if (seen !== 1'b0) $display("FAIL stray_rvalid got activity=%b want 0", seen); else n_pass++;
    endtask

    task automatic test_random();
        logic [3:0] tys [12];
        logic [3:0]  ty;
        logic [31:0] addr, sd, rdat;
        logic [4:0]  rd;
        logic        err;
        int          gd, rvd;
        tys = '{LB, LH, LW, LD, LBU, LHU, LWU, SB, SH, SW, SD, NONE};
        for (int t = 0; t < 60; t++) begin
            ty   = tys[$urandom_range(11)];
            addr = $urandom;
            sd   = $urandom;
            rdat = $urandom;
            rd   = 5'($urandom_range(31));
            err  = ($urandom_range(7) == 0);
            gd   = $urandom_range(3);
            rvd  = $urandom_range(2);
            model(ty, addr, sd, rd, gd, rvd, rdat, err);
            run_txn(ty, addr, sd, rd, gd, rvd, rdat, err);
            n_chk++; if (o_timeout) $display("FAIL rnd_timeout t=%0d no resp_valid", t); else n_pass++;
            n_chk++; if ({o_rdata, o_rwe, o_mis, o_berr, o_rd} !== {e_data, e_rwe, e_mis, e_berr, rd})
                $display("FAIL rnd_resp t=%0d ty=%h a=%h got %h/%b/%b/%b/%0d want %h/%b/%b/%b/%0d",
                         t, ty, addr, o_rdata, o_rwe, o_mis, o_berr, o_rd, e_data, e_rwe, e_mis, e_berr, rd);
            else n_pass++;
            n_chk++; if (o_resp_cyc !== e_lat || !o_one_cycle)
                $display("FAIL rnd_lat t=%0d got %0d pulse_ok=%b want %0d", t, o_resp_cyc, o_one_cycle, e_lat); else n_pass++;
            if (!e_mis) begin
                n_chk++; if ({o_daddr, o_dwdata, o_dsel, o_dwe} !== {e_daddr, e_wdata, e_sel, e_dwe} || o_unstable)
                    $display("FAIL rnd_bus t=%0d got %h/%h/%b/%b want %h/%h/%b/%b",
                             t, o_daddr, o_dwdata, o_dsel, o_dwe, e_daddr, e_wdata, e_sel, e_dwe);
                else n_pass++;
            end else begin
                n_chk++; if (o_req_cycles !== 0) $display("FAIL rnd_nobus t=%0d got %0d want 0", t, o_req_cycles); else n_pass++;
            end
        end
    endtask

    initial begin
        n_chk = 0; n_pass = 0;
        rst_n = 0; req_valid_i = 0; ls_type_i = NONE; addr_i = '0;
        store_data_i = '0; rd_i = '0; dbus_gnt_i = 0;
        dbus_rvalid_i = 0; dbus_rdata_i = '0; dbus_err_i = 0;
        repeat (2) @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        test_reset();
        test_lb_sign();
        test_half();
        test_misalign();
        test_gnt_delay();
        test_bus_err();
        test_reset_in_wait();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
